// File: rtl/hilotof_result_fifo_pkg.sv
// Shared constants for the hilotof result FIFO and its storage array.
package hilotof_result_fifo_pkg;

  localparam int unsigned HILOTOF_WORD_WIDTH = 32;
  localparam int unsigned FIFO_DEPTH_LOG2    = 4;

endpackage

// File: rtl/hilotof_fifo_mem.sv
// Simple dual-port storage: registered write, asynchronous read.
module hilotof_fifo_mem
  import hilotof_result_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = HILOTOF_WORD_WIDTH,
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  clock,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  // Not reset: contents are only observable through a valid head pointer.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/hilotof_result_fifo.sv
// First-word-fall-through elastic buffer between the DUT result port and hilotof_io,
// with sticky overflow reporting and synchronous flush on DUT reset.
module hilotof_result_fifo
  import hilotof_result_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = HILOTOF_WORD_WIDTH,
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  clock,
  input  logic                  sys_reset_n,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_wr_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;
  assign w_wr_en = w_push && sys_reset_n && !flush;

  always_ff @(posedge clock) begin
    if (!sys_reset_n || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)             r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      if (w_pop)              r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  hilotof_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clock     (clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rd_data (out_data)
  );

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign level     = r_wr_ptr - r_rd_ptr;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_hilotof_result_fifo.sv
// Directed self-checking bench for hilotof_result_fifo.
module tb_hilotof_result_fifo;

  logic        clock = 1'b0;
  logic        sys_reset_n;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  hilotof_result_fifo dut (
    .clock       (clock),
    .sys_reset_n (sys_reset_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and checks happen 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    logic        stable;
    sys_reset_n = 1'b0;
    flush       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;

    // 1: reset
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    sys_reset_n = 1'b1;
    step();

    // 2: ordering
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      step();
      if (i == 1) chk("ord_fwft_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    chk("ord_level5", 32'(level), 32'd5);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("ord_valid", 32'(out_valid), 32'd1);
      chk("ord_data",  out_data,       32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("ord_level0", 32'(level),     32'd0);
    chk("ord_empty",  32'(out_valid), 32'd0);

    // 3: full and overflow
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA000_0000 + 32'(i);
      if (i == 16) chk("full_in_ready", 32'(in_ready), 32'd0);
      step();
      if (i == 15) chk("full_ovf_not_yet", 32'(overflow), 32'd0);
    end
    in_valid = 1'b0;
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_level16",  32'(level),    32'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("full_drain", out_data, 32'hA000_0000 + 32'(i));
      step();
      if (i == 0) chk("full_ready_back", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    chk("full_drained",  32'(out_valid), 32'd0);
    chk("ovf_sticky",    32'(overflow),  32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ovf_flushed", 32'(overflow), 32'd0);

    // 4: simultaneous push/pop across pointer wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 32'hB000_0000 + 32'(i);
      step();
      chk("wrap_level", 32'(level), 32'd1);
      chk("wrap_data",  out_data,   32'hB000_0000 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("wrap_end_level", 32'(level), 32'd0);

    // 5: flush mid-burst
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC000_0000 + 32'(i);
      step();
    end
    chk("flush_pre_level", 32'(level), 32'd6);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_level",    32'(level),     32'd0);
    chk("flush_valid",    32'(out_valid), 32'd0);
    chk("flush_overflow", 32'(overflow),  32'd0);
    step();
    chk("flush_word_gone", 32'(level), 32'd0);

    // 6: paced consumer with a 4096-cycle gap before each pop
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hD000_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      held   = out_data;
      stable = 1'b1;
      for (int c = 0; c < 4096; c++) begin
        step();
        if (out_data !== held || out_valid !== 1'b1) stable = 1'b0;
      end
      chk("pace_stable", 32'(stable), 32'd1);
      chk("pace_data",   out_data,    32'hD000_0000 + 32'(k));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pace_level", 32'(level), 32'(2 - k));
    end
    chk("pace_overflow", 32'(overflow),  32'd0);
    chk("pace_empty",    32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
